// File: rtl/regfile_sb_if.sv
// Bundle of read, writeback, issue and flush signals between decode/writeback and regfile_sb.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic [XLEN-1:0] rd_data1;
  logic [XLEN-1:0] rd_data2;
  logic            rd_busy1;
  logic            rd_busy2;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            iss_full;
  logic            flush;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, iss_full
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, iss_full
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file (x0 hardwired to zero) with per-register pending-writer counters
// so decode can detect RAW hazards directly from the read ports.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int PCW    = 2,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  localparam logic [PCW-1:0] CNT_MAX = {PCW{1'b1}};

  logic [XLEN-1:0] regs    [NREG];
  logic [PCW-1:0]  cnt     [NREG];
  logic [PCW-1:0]  cnt_nxt [NREG];
  logic            hit1;
  logic            hit2;
  logic            iss_ok;

  function automatic logic [XLEN-1:0] read_sel(
    input logic            live,
    input logic [AW-1:0]   addr,
    input logic            hit,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] stored
  );
    if (!live || addr == '0) return '0;
    if (hit) return wdata;
    return stored;
  endfunction

  // The last outstanding writer retiring this cycle is forwarded, so the operand is not busy.
  function automatic logic busy_sel(
    input logic [AW-1:0]  addr,
    input logic [PCW-1:0] c,
    input logic           hit,
    input logic           iss_same
  );
    if (addr == '0 || c == '0) return 1'b0;
    if (hit && c == PCW'(1) && !iss_same) return 1'b0;
    return 1'b1;
  endfunction

  always_comb begin
    hit1 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr1);
    hit2 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr2);
    bus.rd_data1 = read_sel(rst_n, bus.rd_addr1, hit1, bus.wr_data, regs[bus.rd_addr1]);
    bus.rd_data2 = read_sel(rst_n, bus.rd_addr2, hit2, bus.wr_data, regs[bus.rd_addr2]);
    bus.rd_busy1 = busy_sel(bus.rd_addr1, cnt[bus.rd_addr1], hit1,
                            bus.iss_en && (bus.iss_addr == bus.rd_addr1));
    bus.rd_busy2 = busy_sel(bus.rd_addr2, cnt[bus.rd_addr2], hit2,
                            bus.iss_en && (bus.iss_addr == bus.rd_addr2));
  end

  // A saturated counter still accepts an issue when the same register retires a writer this cycle.
  assign bus.iss_full = (bus.iss_addr != '0) && (cnt[bus.iss_addr] == CNT_MAX) &&
                        !(bus.wr_en && (bus.wr_addr == bus.iss_addr));
  assign iss_ok = bus.iss_en && (bus.iss_addr != '0) && !bus.iss_full && !bus.flush;

  always_comb begin
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (bus.flush) begin
        cnt_nxt[r] = '0;
      end else if (iss_ok && (bus.iss_addr == AW'(r))) begin
        if (!(bus.wr_en && (bus.wr_addr == AW'(r)))) cnt_nxt[r] = cnt[r] + PCW'(1);
      end else if (bus.wr_en && (bus.wr_addr == AW'(r)) && (cnt[r] != '0)) begin
        cnt_nxt[r] = cnt[r] - PCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      if (bus.wr_en && (bus.wr_addr != '0)) regs[bus.wr_addr] <= bus.wr_data;
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file with a per-register pending-write scoreboard, for the pipelined RV32I core.
- Two asynchronous read ports, one synchronous write port, and an issue port that marks a destination register as pending.
- Provides optional write-to-read bypass and per-operand busy flags, so decode can stall on RAW hazards without a separate hazard unit.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers (power of 2, >=2).
- AW, 5, address width; must equal log2(NREG).
- PCW, 2, width of each pending counter; max in-flight writers per register = 2^PCW-1.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr1  in  AW  read port 1 address.
- rd_addr2  in  AW  read port 2 address.
- rd_data1  out  XLEN  read port 1 data.
- rd_data2  out  XLEN  read port 2 data.
- rd_busy1  out  1  register at rd_addr1 still has an outstanding writer.
- rd_busy2  out  1  same for rd_addr2.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback address.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  issue of an instruction that will write iss_addr.
- iss_addr  in  AW  destination of issued instruction.
- iss_full  out  1  pending counter of iss_addr is saturated; issue will be dropped.
- flush  in  1  clear all pending counters (pipeline flush).

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0, all pending counters = 0. Outputs are combinational from this state: rd_data = 0 and rd_busy = 0 while in reset.
- Reads are combinational, zero latency.
  - rd_addrN == 0 -> rd_data = 0, rd_busy = 0, always.
  - BYPASS=1, wr_en=1, wr_addr == rd_addrN != 0 -> rd_data = wr_data.
  - Otherwise rd_data = stored value.
- Write: on a clk edge with wr_en=1 and wr_addr != 0, reg[wr_addr] <= wr_data. A write to x0 has no effect.
- Pending counter cnt[r], updated per edge. Evaluation order: flush, then issue/write:
  - flush=1 -> all cnt <= 0. Same-cycle iss_en is ignored. Same-cycle wr_en still updates data.
  - iss_en=1, iss_addr != 0, cnt[iss_addr] < 2^PCW-1 -> cnt +1.
  - wr_en=1, wr_addr != 0, cnt[wr_addr] > 0 -> cnt -1. A write to a register with cnt = 0 updates data only; the counter stays 0 and never underflows.
  - Issue and write to the same register in the same cycle -> cnt unchanged (net 0). This holds even at saturation: the issue is accepted, because the write frees the slot.
  - Issue to x0 never changes any counter.
- iss_full = (iss_addr != 0) and cnt[iss_addr] == 2^PCW-1 and not (wr_en and wr_addr == iss_addr). While iss_full=1, the issue is dropped and state is unchanged; the producer must hold.
- rd_busyN = cnt[rd_addrN] != 0, with one exception: when BYPASS=1, a same-cycle write to rd_addrN with cnt == 1 and no same-cycle issue to that register -> busy = 0, since the data is forwarded. When BYPASS=0, busy reflects cnt before the edge.
- Read addresses are don't-care for state; reads never modify state.
- Reset asserted mid-operation clears data and counters immediately. There is no partial write on the deasserting edge.

Test Plan:
- Reset then write x2=123456789 (wr_en=1, one cycle); read rd_addr1=2 next cycle -> rd_data1=123456789, rd_busy1=0; read rd_addr2=0 -> 0.
- Write x0=54321 -> x0 still reads 0; issue to x0 -> rd_busy for x0 stays 0 and no counter changes.
- BYPASS=1: wr_en=1, wr_addr=1, wr_data=54321123 with rd_addr1=1 in the same cycle -> rd_data1=54321123 combinationally. BYPASS=0 instance -> old value until the next edge.
- Issue x5 three times (PCW=2) -> rd_busy=1 and iss_full=1 for iss_addr=5; a 4th issue is dropped. Three writebacks to x5 -> busy clears only after the 3rd (same cycle when BYPASS=1). Issue and writeback to x5 in the same cycle while saturated -> accepted, counter stays 3.
- Issue x7 and x8, assert flush with a concurrent issue to x9 and write x7=0xA5 -> next cycle x7, x8 and x9 are all not busy, and x7 reads 0xA5.
- Write x3=0xDEADBEEF and issue x3, then pull rst_n low mid-cycle -> x3 reads 0 and rd_busy=0 immediately, before any clock edge.
